// File: rtl/playbus_memory.sv
// PlayBus data-bus model: ROM/RAM/switch sources and RAM/LED sinks on a shared 4-bit bus.
// BUS is combinational; RAM, LED, WRCNT and CONTEND update at the qualifying CK2HZ edge.
module playbus_memory #(
  parameter logic [63:0] ROM_INIT  = 64'h0123_4567_89AB_CDEF,
  parameter logic [3:0]  FLOAT_VAL = 4'hF,
  parameter logic [3:0]  CONT_VAL  = 4'h0
) (
  input  logic       CK2HZ,
  input  logic       n_CLR,
  input  logic [3:0] ADD,
  input  logic [3:0] SW,
  input  logic       n_ROMO,
  input  logic       n_RAMO,
  input  logic       n_RAMW,
  input  logic       n_SWBEN,
  input  logic       LEDLTCH,
  output logic [3:0] BUS,
  output logic [3:0] LED,
  output logic       CONTEND,
  output logic [3:0] WRCNT
);

  logic [3:0] ram [16];
  logic [3:0] bus_val;
  logic [3:0] rom_word;
  logic [1:0] nsrc;
  logic       conflict;
  logic       wr_q;
  logic       lt_q;
  logic       wr_edge;
  logic       lt_edge;

  assign rom_word = ROM_INIT[{ADD, 2'b00} +: 4];
  assign nsrc     = 2'(!n_ROMO) + 2'(!n_RAMO) + 2'(!n_SWBEN);
  // Reading and writing RAM in the same cycle is treated as a fight on the bus.
  assign conflict = (nsrc > 2'd1) || (!n_RAMO && !n_RAMW);

  always_comb begin
    bus_val = FLOAT_VAL;
    if (conflict)      bus_val = CONT_VAL;
    else if (!n_ROMO)  bus_val = rom_word;
    else if (!n_RAMO)  bus_val = ram[ADD];
    else if (!n_SWBEN) bus_val = SW;
  end

  assign BUS     = bus_val;
  assign wr_edge = !n_RAMW && wr_q && !conflict;
  assign lt_edge = LEDLTCH && !lt_q && !conflict;

  always_ff @(posedge CK2HZ) begin
    if (!n_CLR) begin
      wr_q    <= 1'b1;
      lt_q    <= 1'b0;
      LED     <= 4'h0;
      CONTEND <= 1'b0;
      WRCNT   <= 4'h0;
      for (int i = 0; i < 16; i++) ram[i] <= 4'h0;
    end else begin
      wr_q <= n_RAMW;
      lt_q <= LEDLTCH;
      if (conflict) CONTEND <= 1'b1;
      if (wr_edge) begin
        ram[ADD] <= bus_val;
        WRCNT    <= WRCNT + 4'd1;
      end
      // Same pre-edge bus value feeds both sinks, so LED sees the data being written.
      if (lt_edge) LED <= bus_val;
    end
  end

endmodule

// File: tb/tb_playbus_memory.sv
// Randomized plus directed bench for playbus_memory against a behavioural bus/memory model.
module tb_playbus_memory;

  localparam logic [63:0] ROM_INIT = 64'h0123_4567_89AB_CDEF;

  logic       clk = 1'b0;
  logic       n_CLR = 1'b0;
  logic [3:0] ADD = 4'h0;
  logic [3:0] SW = 4'h0;
  logic       n_ROMO = 1'b1, n_RAMO = 1'b1, n_RAMW = 1'b1, n_SWBEN = 1'b1;
  logic       LEDLTCH = 1'b0;
  logic [3:0] BUS, LED, WRCNT;
  logic       CONTEND;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the spec says the memory and latches hold.
  int  m_ram [16];
  int  m_led, m_wrcnt;
  bit  m_cont;
  bit  m_ramw_was_active, m_ltch_was_high;

  playbus_memory dut (
    .CK2HZ(clk), .n_CLR(n_CLR), .ADD(ADD), .SW(SW),
    .n_ROMO(n_ROMO), .n_RAMO(n_RAMO), .n_RAMW(n_RAMW), .n_SWBEN(n_SWBEN),
    .LEDLTCH(LEDLTCH), .BUS(BUS), .LED(LED), .CONTEND(CONTEND), .WRCNT(WRCNT)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_bus(output int val, output bit fight);
    int drivers;
    drivers = 0;
    if (!n_ROMO)  drivers++;
    if (!n_RAMO)  drivers++;
    if (!n_SWBEN) drivers++;
    fight = (drivers >= 2) || (!n_RAMO && !n_RAMW);
    if (fight)             val = 0;
    else if (drivers == 0) val = 15;
    else if (!n_ROMO)      val = int'((ROM_INIT >> (4 * int'(ADD))) & 64'hF);
    else if (!n_RAMO)      val = m_ram[ADD];
    else                   val = int'(SW);
  endfunction

  function automatic void model_edge(input int val, input bit fight);
    if (!n_CLR) begin
      foreach (m_ram[i]) m_ram[i] = 0;
      m_led = 0; m_wrcnt = 0; m_cont = 0;
      m_ramw_was_active = 0; m_ltch_was_high = 0;
    end else begin
      if (fight) m_cont = 1;
      if (!n_RAMW && !m_ramw_was_active && !fight) begin
        m_ram[ADD] = val;
        m_wrcnt = (m_wrcnt + 1) % 16;
      end
      if (LEDLTCH && !m_ltch_was_high && !fight) m_led = val;
      m_ramw_was_active = !n_RAMW;
      m_ltch_was_high   = LEDLTCH;
    end
  endfunction

  task automatic tick();
    int  eb;
    bit  ef;
    #1;
    model_bus(eb, ef);
    check("bus", BUS, 4'(eb));
    @(posedge clk);
    model_edge(eb, ef);
    #1;
    check("led", LED, 4'(m_led));
    check("contend", {3'b0, CONTEND}, {3'b0, m_cont});
    check("wrcnt", WRCNT, 4'(m_wrcnt));
  endtask

  task automatic idle();
    n_ROMO = 1; n_RAMO = 1; n_RAMW = 1; n_SWBEN = 1; LEDLTCH = 0;
  endtask

  task automatic do_reset();
    n_CLR = 0; tick(); n_CLR = 1;
  endtask

  initial begin
    foreach (m_ram[i]) m_ram[i] = 0;
    m_led = 0; m_wrcnt = 0; m_cont = 0;
    m_ramw_was_active = 0; m_ltch_was_high = 0;

    // Reset state and cleared RAM
    idle(); n_CLR = 0; tick(); tick(); n_CLR = 1;
    #1;
    check("rst_bus_float", BUS, 4'hF);
    check("rst_led", LED, 4'h0);
    check("rst_wrcnt", WRCNT, 4'h0);
    n_RAMO = 0;
    for (int a = 0; a < 16; a++) begin
      ADD = 4'(a); #1;
      check("rst_ram_zero", BUS, 4'h0);
      tick();
    end
    idle();

    // ROM read and single LED latch over a held strobe
    n_ROMO = 0; ADD = 4'd3; #1;
    check("rom3", BUS, 4'hC);
    LEDLTCH = 1;
    tick(); check("led_first", LED, 4'hC);
    ADD = 4'd5; tick(); tick();
    check("led_held", LED, 4'hC);
    idle(); tick();

    // Held write strobe writes once
    SW = 4'h5; n_SWBEN = 0; ADD = 4'd9; n_RAMW = 0;
    repeat (4) tick();
    idle(); tick();
    check("one_write", WRCNT, 4'd1);
    n_RAMO = 0; ADD = 4'd9; #1;
    check("ram9", BUS, 4'h5);
    tick(); idle();

    // Contention: bus forced, write suppressed, flag sticky
    n_ROMO = 0; n_SWBEN = 0; n_RAMW = 0; #1;
    check("cont_bus", BUS, 4'h0);
    tick();
    check("cont_flag", {3'b0, CONTEND}, 4'd1);
    check("cont_nowrite", WRCNT, 4'd1);
    idle(); tick(); tick();
    check("cont_sticky", {3'b0, CONTEND}, 4'd1);
    do_reset();
    check("cont_cleared", {3'b0, CONTEND}, 4'd0);

    // 17 strobes wrap the counter
    n_SWBEN = 0;
    for (int k = 0; k < 17; k++) begin
      ADD = 4'($urandom_range(0, 15)); SW = 4'($urandom_range(0, 15));
      n_RAMW = 0; tick(); n_RAMW = 1; tick();
    end
    check("wrap", WRCNT, 4'd1);

    // Reset with strobe held: no write during reset, write on first released edge
    SW = 4'h7; ADD = 4'd4; n_RAMW = 0; n_CLR = 0; tick();
    check("rst_wrcnt2", WRCNT, 4'd0);
    n_CLR = 1; tick();
    check("post_rst_write", WRCNT, 4'd1);
    idle(); n_RAMO = 0; ADD = 4'd4; #1;
    check("ram4", BUS, 4'h7);
    tick(); idle(); tick();

    // Simultaneous write and latch share the pre-edge bus value
    n_SWBEN = 0; SW = 4'hA; ADD = 4'd2; n_RAMW = 0; LEDLTCH = 1;
    tick();
    check("sim_led", LED, 4'hA);
    idle(); n_RAMO = 0; ADD = 4'd2; #1;
    check("sim_ram2", BUS, 4'hA);
    tick(); idle();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      n_CLR   = ($urandom_range(0, 49) != 0);
      ADD     = 4'($urandom_range(0, 15));
      SW      = 4'($urandom_range(0, 15));
      n_ROMO  = ($urandom_range(0, 3) != 0);
      n_RAMO  = ($urandom_range(0, 2) != 0);
      n_SWBEN = ($urandom_range(0, 3) != 0);
      n_RAMW  = ($urandom_range(0, 2) != 0);
      LEDLTCH = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
